// File: rtl/osc_pkg.sv
// Definitions shared across the acquisition path: ADC frame geometry,
// converter FSM states and the parallel sample type used by the trigger stage.
package osc_pkg;

    localparam int ADC_W          = 12;
    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_LEAD_BITS  = 4;

    typedef enum logic [1:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        DONE
    } adc_state_t;

    typedef logic [ADC_W-1:0]          sample_t;
    typedef logic [ADC_FRAME_BITS-1:0] adc_frame_t;

    // A healthy AD7476A frame always starts with four zero bits.
    function automatic logic lead_err(input adc_frame_t frame);
        return |frame[ADC_FRAME_BITS-1 -: ADC_LEAD_BITS];
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SPI serial clock generator: CLK_DIV clk cycles per half-period, idles high,
// and flags the cycle whose closing edge will move SCLK up or down.
module adc_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic hold_high,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int            HW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HW-1:0] HLAST = HW'(CLK_DIV - 1);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          sclk_q, sclk_d;
    logic          term;

    always_comb begin
        term   = run && (hcnt_q == HLAST);
        rise   = term && !sclk_q;
        // fall marks the end of a high half-period; with hold_high the
        // line stays high so the frame can close without an extra edge
        fall   = term && sclk_q;
        hcnt_d = hcnt_q;
        sclk_d = sclk_q;
        if (!run) begin
            hcnt_d = '0;
            sclk_d = 1'b1;
        end else if (term) begin
            hcnt_d = '0;
            if (rise) begin
                sclk_d = 1'b1;
            end else if (!hold_high) begin
                sclk_d = 1'b0;
            end
        end else begin
            hcnt_d = hcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q <= '0;
            sclk_q <= 1'b1;
        end else begin
            hcnt_q <= hcnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/adc_spi_reader.sv
// AD7476A-class SPI reader: starts a 16-clock conversion every SAMPLE_PERIOD
// cycles while enabled and presents each result with a one-cycle strobe.
module adc_spi_reader
    import osc_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int SAMPLE_PERIOD = 80
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            adc_sdata,
    output logic            adc_cs_n,
    output logic            adc_sclk,
    output logic [ADC_W-1:0] sample_data,
    output logic            sample_valid,
    output logic            frame_err
);

    localparam int            PW       = $clog2(SAMPLE_PERIOD);
    localparam logic [PW-1:0] PLAST    = PW'(SAMPLE_PERIOD - 1);
    localparam int            BW       = $clog2(ADC_FRAME_BITS + 1);
    localparam logic [BW-1:0] BITS_ALL = BW'(ADC_FRAME_BITS);

    adc_state_t    state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    adc_frame_t    shift_q, shift_d;
    logic          cs_n_q, cs_n_d;
    sample_t       data_q, data_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    logic start;
    logic run;
    logic hold_high;
    logic sclk_rise;
    logic sclk_fall;

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .hold_high (hold_high),
        .sclk      (adc_sclk),
        .rise      (sclk_rise),
        .fall      (sclk_fall)
    );

    always_comb begin
        start     = enable && (pcnt_q == '0) && (state_q == IDLE);
        run       = (state_q == CS_SETUP) || (state_q == SHIFT);
        hold_high = (bitcnt_q == BITS_ALL);

        // period counter free-runs while enabled, so the start rate has no jitter
        if (!enable) begin
            pcnt_d = '0;
        end else if (pcnt_q == PLAST) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + 1'b1;
        end

        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        cs_n_d   = cs_n_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cs_n_d   = 1'b0;
                    bitcnt_d = '0;
                    shift_d  = '0;
                    state_d  = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (sclk_fall) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    shift_d  = {shift_q[ADC_FRAME_BITS-2:0], adc_sdata};
                    bitcnt_d = bitcnt_q + 1'b1;
                end
                if (sclk_fall && hold_high) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                cs_n_d  = 1'b1;
                data_d  = shift_q[ADC_W-1:0];
                valid_d = 1'b1;
                err_d   = lead_err(shift_q);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pcnt_q   <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            cs_n_q   <= 1'b1;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            cs_n_q   <= cs_n_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign adc_cs_n     = cs_n_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: two instances (default timing and CLK_DIV=1), an
// ADC model fed from per-instance word queues and a scoreboard monitor.
module tb_adc_spi_reader;

    localparam int CD0 = 2;
    localparam int SP0 = 80;
    localparam int CD1 = 1;
    localparam int SP1 = 35;

    typedef struct packed {
        logic [11:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        en    [2];
    logic        sdata [2];
    logic        cs_n  [2];
    logic        sclk  [2];
    logic [11:0] data  [2];
    logic        valid [2];
    logic        err   [2];

    always #5 clk = ~clk;

    adc_spi_reader #(.CLK_DIV(CD0), .SAMPLE_PERIOD(SP0)) dut0 (
        .clk(clk), .rst(rst[0]), .enable(en[0]), .adc_sdata(sdata[0]),
        .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]), .sample_data(data[0]),
        .sample_valid(valid[0]), .frame_err(err[0])
    );

    adc_spi_reader #(.CLK_DIV(CD1), .SAMPLE_PERIOD(SP1)) dut1 (
        .clk(clk), .rst(rst[1]), .enable(en[1]), .adc_sdata(sdata[1]),
        .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]), .sample_data(data[1]),
        .sample_valid(valid[1]), .frame_err(err[1])
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model and scoreboard state
    logic [15:0] wq   [2][$];
    exp_t        expq [2][$];
    int          vcyc [2][$];
    logic [15:0] w      [2];
    int          rises  [2];
    int          falls  [2];
    int          tcs    [2];
    int          trise  [2];
    int          nvalid [2];
    logic        active [2];
    logic        pcs    [2];
    logic        psclk  [2];
    logic        pvalid [2];
    logic [11:0] held   [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            w[i] = '0; rises[i] = 0; falls[i] = 0; tcs[i] = 0; trise[i] = 0;
            nvalid[i] = 0; active[i] = 1'b0; pcs[i] = 1'b1; psclk[i] = 1'b1;
            pvalid[i] = 1'b0; held[i] = '0; sdata[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                exp_t e;
                if (rst[i]) held[i] = '0;
                if (!cs_n[i] && pcs[i]) begin
                    if (wq[i].size() > 0) w[i] = wq[i].pop_front();
                    else w[i] = 16'($urandom);
                    expq[i].push_back({w[i][11:0], |w[i][15:12]});
                    if (i == 1 && trise[1] > 0) chk("cs_high_gap", 32'(cyc - trise[1]), 32'd1);
                    rises[i] = 0; falls[i] = 0; tcs[i] = cyc; active[i] = 1'b1;
                    sdata[i] = w[i][15];
                end
                if (active[i] && !cs_n[i] && !sclk[i] && psclk[i]) begin
                    falls[i]++;
                    if (rises[i] < 16) sdata[i] = w[i][15 - rises[i]];
                end
                if (active[i] && sclk[i] && !psclk[i]) rises[i]++;
                if (active[i] && cs_n[i] && !pcs[i]) begin
                    active[i] = 1'b0;
                    if (rst[i]) begin
                        if (expq[i].size() > 0) void'(expq[i].pop_back());
                    end else begin
                        chk("sclk_falls", 32'(falls[i]), 32'd16);
                        if (i == 1) trise[1] = cyc;
                    end
                end
                if (valid[i]) begin
                    chk("valid_width", 32'(pvalid[i]), 32'd0);
                    if (expq[i].size() == 0) begin
                        chk("unexpected_valid", 32'(expq[i].size()), 32'd1);
                    end else begin
                        e = expq[i].pop_front();
                        chk("sample_data", 32'(data[i]), 32'(e.data));
                        chk("frame_err", 32'(err[i]), 32'(e.err));
                    end
                    chk("valid_latency", 32'(cyc - tcs[i]), (i == 0) ? 32'(1 + 33*CD0) : 32'(1 + 33*CD1));
                    held[i] = data[i];
                    nvalid[i]++;
                    vcyc[i].push_back(cyc);
                end else begin
                    chk("data_hold", 32'(data[i]), 32'(held[i]));
                    chk("err_idle", 32'(err[i]), 32'd0);
                end
                pcs[i] = cs_n[i]; psclk[i] = sclk[i]; pvalid[i] = valid[i];
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int i, input int n0, input int bound);
        int k = 0;
        while (nvalid[i] == n0 && k < bound) begin
            step();
            k++;
        end
        chk("valid_timeout", 32'(nvalid[i] != n0), 32'd1);
    endtask

    task automatic wait_rise(input int i, input int r, input int bound);
        int k = 0;
        while (!(active[i] && rises[i] >= r) && k < bound) begin
            step();
            k++;
        end
        chk("rise_timeout", 32'(active[i] && rises[i] >= r), 32'd1);
    endtask

    task automatic chk_intervals(input int i, input int n, input int period);
        int sz = vcyc[i].size();
        for (int k = sz - n + 1; k < sz; k++)
            chk("valid_interval", 32'(vcyc[i][k] - vcyc[i][k-1]), 32'(period));
    endtask

    initial begin
        int n0;
        int lowcnt;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            en[i]  = 1'b0;
        end
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            chk("rst_cs_n", 32'(cs_n[i]), 32'd1);
            chk("rst_sclk", 32'(sclk[i]), 32'd1);
            chk("rst_data", 32'(data[i]), 32'd0);
            chk("rst_valid", 32'(valid[i]), 32'd0);
            chk("rst_err", 32'(err[i]), 32'd0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        repeat (2) step();

        // continuous conversions, fixed patterns
        wq[0].push_back(16'h0ABC);
        wq[0].push_back(16'h0000);
        wq[0].push_back(16'h0FFF);
        wq[0].push_back(16'h0555);
        en[0] = 1'b1;
        step();
        chk("cs_fall_on_enable", 32'(cs_n[0]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            n0 = nvalid[0];
            wait_valid(0, n0, 2*SP0);
        end
        en[0] = 1'b0;
        chk_intervals(0, 4, SP0);
        repeat (20) step();

        // leading bit set
        wq[0].push_back(16'h8123);
        n0 = nvalid[0];
        en[0] = 1'b1;
        wait_valid(0, n0, 2*SP0);
        en[0] = 1'b0;
        repeat (20) step();

        // enable dropped mid-frame
        wq[0].push_back(16'($urandom));
        n0 = nvalid[0];
        en[0] = 1'b1;
        wait_rise(0, 8, 2*SP0);
        en[0] = 1'b0;
        wait_valid(0, n0, 2*SP0);
        lowcnt = 0;
        repeat (500) begin
            step();
            if (!cs_n[0]) lowcnt++;
        end
        chk("cs_idle_after_disable", 32'(lowcnt), 32'd0);
        wq[0].push_back(16'($urandom));
        n0 = nvalid[0];
        en[0] = 1'b1;
        step();
        chk("cs_fall_on_reenable", 32'(cs_n[0]), 32'd0);
        wait_valid(0, n0, 2*SP0);
        en[0] = 1'b0;
        repeat (20) step();

        // reset mid-frame
        wq[0].push_back(16'($urandom));
        n0 = nvalid[0];
        en[0] = 1'b1;
        wait_rise(0, 10, 2*SP0);
        rst[0] = 1'b1;
        #1;
        chk("rst_async_cs_n", 32'(cs_n[0]), 32'd1);
        chk("rst_async_sclk", 32'(sclk[0]), 32'd1);
        chk("rst_async_data", 32'(data[0]), 32'd0);
        repeat (3) step();
        chk("no_valid_in_reset", 32'(nvalid[0] - n0), 32'd0);
        wq[0].push_back(16'($urandom));
        rst[0] = 1'b0;
        wait_valid(0, n0, 2*SP0);
        en[0] = 1'b0;
        chk("one_valid_after_reset", 32'(nvalid[0] - n0), 32'd1);
        repeat (20) step();

        // fastest SCLK, back-to-back frames
        wq[1].push_back(16'h07E1);
        wq[1].push_back(16'($urandom));
        wq[1].push_back(16'($urandom));
        en[1] = 1'b1;
        step();
        chk("cs_fall_on_enable_div1", 32'(cs_n[1]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            n0 = nvalid[1];
            wait_valid(1, n0, 2*SP1);
        end
        en[1] = 1'b0;
        chk_intervals(1, 3, SP1);

        repeat (50) step();
        chk("exp_drained_0", 32'(expq[0].size()), 32'd0);
        chk("exp_drained_1", 32'(expq[1].size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got cycle %0d, expected finish", cyc);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/adc_spi_reader.md
# adc_spi_reader

Serial front end of the oscilloscope acquisition path. Drives the 12-bit SPI ADC (AD7476A-class, 16-clock frame: 4 leading zeros then 12 data bits MSB first) at a fixed conversion rate. Presents each result as a parallel 12-bit sample with a one-cycle valid strobe. Sits directly upstream of the trigger stage, whose `data_input` it feeds.

## Interface
Parameters:
- `CLK_DIV`, default 2: clk cycles per SCLK half-period. SCLK = clk/(2·CLK_DIV), which gives 10 MHz at 40 MHz clk. Must be ≥1.
- `SAMPLE_PERIOD`, default 80: clk cycles between conversion starts. Must be ≥ 33·CLK_DIV+2. The default gives 500 kSPS.

Ports:
- `clk` in 1: system clock, 40 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: allows new conversions to start.
- `adc_sdata` in 1: ADC serial data output.
- `adc_cs_n` out 1: ADC chip select, active low.
- `adc_sclk` out 1: ADC serial clock. Idles high.
- `sample_data` out 12: last completed sample. Held until the next completed sample.
- `sample_valid` out 1: one-cycle pulse when `sample_data` updates.
- `frame_err` out 1: one-cycle pulse, concurrent with `sample_valid`, when any leading bit was 1.

## Operation
- Period counter `pcnt` counts 0..SAMPLE_PERIOD-1 and wraps.
  - It is held at 0 while `enable`=0.
  - A conversion starts when `pcnt`==0, `enable`=1 and the FSM is in IDLE.
- FSM states are IDLE → CS_SETUP → SHIFT → DONE → IDLE.
  - IDLE: `adc_cs_n`=1, `adc_sclk`=1. On start, assert `adc_cs_n`=0 and go to CS_SETUP.
  - CS_SETUP: hold for CLK_DIV cycles with SCLK high, then go to SHIFT.
  - SHIFT: 16 SCLK periods. Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
    - `adc_sdata` is sampled on the clk edge that drives SCLK low→high.
    - Each sampled bit shifts MSB-first into a 16-bit register.
    - Bit counter runs 0..15. After the 16th rising edge, go to DONE with SCLK high.
  - DONE: one cycle.
    - Deassert `adc_cs_n`=1.
    - Load `sample_data` = shift[11:0] and pulse `sample_valid`.
    - `frame_err` = |shift[15:12]`.
    - Return to IDLE.
- `enable` falling mid-frame: the current frame completes normally, including `sample_valid`. No new start follows.
- `enable` rising: the first start occurs on the next cycle, because `pcnt`==0.
- The start condition is evaluated in IDLE only, so a start can never overlap a frame. SAMPLE_PERIOD violations are a parameter error, not a runtime case.
- `rst` mid-frame, immediately (asynchronous):
  - `adc_cs_n`=1, `adc_sclk`=1.
  - FSM to IDLE, counters to 0.
  - Shift register discarded; no `sample_valid`.

## Timing
- Reset values:
  - `adc_cs_n`=1, `adc_sclk`=1.
  - `sample_data`=0, `sample_valid`=0, `frame_err`=0.
  - FSM=IDLE, `pcnt`=0.
- All outputs are registered.
- The start cycle is T0, where `pcnt`==0 and the FSM is in IDLE. The following timing holds:
  - `adc_cs_n` falls at T0+1.
  - The first SCLK falling edge is at T0+1+CLK_DIV.
  - Rising edge k (k=1..16) is at T0+1+CLK_DIV+(2k-1)·CLK_DIV.
  - `adc_cs_n` rises and `sample_valid` pulses at T0+2+CLK_DIV+32·CLK_DIV. With defaults that is T0+68.
- Conversion rate is exactly one frame per SAMPLE_PERIOD cycles while `enable`=1, with zero jitter.
- ADC data must be stable at the sampling clk edge. The bench model updates `adc_sdata` ≤1 clk after each SCLK falling edge, and after `adc_cs_n` falls for the first bit.

## Structure
- `osc_pkg` holds the shared definitions:
  - `ADC_W`=12, `ADC_FRAME_BITS`=16, `ADC_LEAD_BITS`=4.
  - The `adc_state_t` enum {IDLE, CS_SETUP, SHIFT, DONE}.
  - The sample type `logic [ADC_W-1:0]`, shared with the trigger stage.
- The natural sub-module is `adc_sclk_gen`. It owns the half-period counter and SCLK toggling, with ports run/rise/fall strobes. The FSM, shift register and period counter stay in the top.

## Test plan
- ADC model returns frame 0x0ABC with defaults:
  - `sample_data`=12'hABC.
  - One-cycle `sample_valid` at T0+68.
  - `frame_err`=0.
  - Exactly 16 SCLK falling edges while `adc_cs_n`=0.
- Continuous `enable` with model values 0x000, 0xFFF, 0x555:
  - Three `sample_valid` pulses exactly 80 cycles apart, with data 0x000, 0xFFF, 0x555.
  - Each `sample_data` is held between pulses.
- Model drives leading bits 0b1000 with data 0x123:
  - `sample_data`=12'h123.
  - `frame_err`=1 in the same cycle as `sample_valid`.
- `enable` dropped at SCLK rising edge 8:
  - The frame completes and `sample_valid` pulses.
  - `adc_cs_n` stays 1 for 500 subsequent cycles.
  - Re-enabling makes `adc_cs_n` fall on the next cycle.
- `rst` asserted at SCLK rising edge 10, held 3 cycles:
  - `adc_cs_n`=1 and `adc_sclk`=1 in the same time step.
  - No `sample_valid`.
  - `sample_data`=0.
  - The next frame after release returns correct data.
- CLK_DIV=1, SAMPLE_PERIOD=35, model 0x7E1:
  - `sample_data`=12'h7E1, `sample_valid` at T0+35.
  - Back-to-back frames with no overlap of `adc_cs_n` low periods.
